// File: rtl/pool_window_gen.sv
// rtl/pool_window_gen.sv - 2x2 stride-2 window extractor with single-row line buffer
module pool_window_gen #(
    parameter  int IL    = 8,
    parameter  int FL    = 12,
    parameter  int MAP_W = 8,
    parameter  int MAP_H = 8,
    localparam int W     = IL + FL,
    localparam int NWIN  = (MAP_W / 2) * (MAP_H / 2),
    localparam int IW    = (NWIN > 1) ? $clog2(NWIN) : 1,
    localparam int CW    = $clog2(MAP_W),
    localparam int RW    = $clog2(MAP_H)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic signed [W-1:0] in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic signed [W-1:0] win [4],
    output logic                win_valid,
    input  logic                pool_idle,
    output logic [IW-1:0]       win_idx,
    output logic                frame_done
);

    logic [CW-1:0]       r_col;
    logic [RW-1:0]       r_row;
    logic [IW-1:0]       r_cnt;
    logic [IW-1:0]       r_win_idx;
    logic                r_win_valid;
    logic                r_frame_done;
    logic signed [W-1:0] r_hold;
    logic signed [W-1:0] r_win [4];
    logic signed [W-1:0] r_line_buf [MAP_W];

    logic          w_accept;
    logic          w_consume;
    logic          w_col_last;
    logic          w_row_last;
    logic [CW-1:0] w_col_left;

    assign in_ready   = !r_win_valid | pool_idle;
    assign w_accept   = in_valid & in_ready;
    assign w_consume  = r_win_valid & pool_idle;
    assign w_col_last = (r_col == CW'(MAP_W - 1));
    assign w_row_last = (r_row == RW'(MAP_H - 1));
    assign w_col_left = r_col & ~CW'(1);

    assign win        = r_win;
    assign win_valid  = r_win_valid;
    assign win_idx    = r_win_idx;
    assign frame_done = r_frame_done;

    // Line buffer and hold register carry no reset; their contents are only read after being rewritten.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            if (!r_row[0]) begin
                r_line_buf[r_col] <= in_data;
            end else if (!r_col[0]) begin
                r_hold <= in_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_col        <= '0;
            r_row        <= '0;
            r_cnt        <= '0;
            r_win_idx    <= '0;
            r_win_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_win[i] <= '0;
            end
        end else begin
            r_frame_done <= 1'b0;
            if (w_consume) begin
                r_win_valid <= 1'b0;
            end
            if (w_accept) begin
                // A window completing on the consume edge overrides the clear: no bubble.
                if (r_row[0] && r_col[0]) begin
                    r_win[0]    <= r_line_buf[w_col_left];
                    r_win[1]    <= r_line_buf[r_col];
                    r_win[2]    <= r_hold;
                    r_win[3]    <= in_data;
                    r_win_valid <= 1'b1;
                    r_win_idx   <= r_cnt;
                    r_cnt       <= (r_cnt == IW'(NWIN - 1)) ? '0 : r_cnt + 1'b1;
                end
                if (w_col_last) begin
                    r_col <= '0;
                    r_row <= w_row_last ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
                r_frame_done <= w_col_last & w_row_last;
            end
        end
    end

endmodule

// File: tb/tb_pool_window_gen.sv
// tb/tb_pool_window_gen.sv - scoreboard bench for pool_window_gen
module tb_pool_window_gen;
    localparam int W    = 20;
    localparam int MW   = 8;
    localparam int MH   = 8;
    localparam int NWIN = 16;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic signed [W-1:0] in_data = '0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic signed [W-1:0] win [4];
    logic                win_valid;
    logic                pool_idle = 1'b0;
    logic [3:0]          win_idx;
    logic                frame_done;

    pool_window_gen #(.IL(8), .FL(12), .MAP_W(MW), .MAP_H(MH)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .win        (win),
        .win_valid  (win_valid),
        .pool_idle  (pool_idle),
        .win_idx    (win_idx),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0]         idx;
        logic [3:0][W-1:0]   p;
    } exp_t;

    exp_t       q[$];
    logic [W-1:0] px [MH][MW];
    int         n_checks = 0;
    int         n_errors = 0;
    int         fd_count = 0;
    bit         fd_pending = 1'b0;
    bit         rand_idle = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor: pop expected window on each consume, check frame_done pulses.
    always @(negedge clk) begin
        if (!reset) begin
            if (win_valid && pool_idle) begin
                if (q.size() == 0) begin
                    check_eq("unexpected_window", 32'(win_idx), 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check_eq("win_idx", 32'(win_idx), e.idx);
                    for (int i = 0; i < 4; i++) begin
                        check_eq($sformatf("win%0d_idx%0d", i, e.idx), {12'b0, win[i]}, {12'b0, e.p[i]});
                    end
                end
            end
            if (fd_pending || frame_done) begin
                check_eq("frame_done", 32'(frame_done), 32'(fd_pending));
                if (frame_done) begin
                    check_eq("frame_done_win_valid", 32'(win_valid), 32'd1);
                    check_eq("frame_done_win_idx", 32'(win_idx), NWIN - 1);
                    fd_count++;
                end
                fd_pending = 1'b0;
            end
        end
    end

    task automatic send_pixel(input int r, input int c);
        bit ok;
        bit done;
        done = 1'b0;
        in_data  = px[r][c];
        in_valid = 1'b1;
        for (int t = 0; t < 2000 && !done; t++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            if (rand_idle) pool_idle = ($urandom_range(2) != 0);
            if (ok) done = 1'b1;
        end
        in_valid = 1'b0;
        if (!done) begin
            check_eq("accept_timeout", 32'd0, 32'd1);
        end else begin
            if ((r % 2 == 1) && (c % 2 == 1)) begin
                exp_t e;
                e.idx  = 32'((r / 2) * (MW / 2) + c / 2);
                e.p[0] = px[r-1][c-1];
                e.p[1] = px[r-1][c];
                e.p[2] = px[r][c-1];
                e.p[3] = px[r][c];
                q.push_back(e);
            end
            if (r == MH - 1 && c == MW - 1) fd_pending = 1'b1;
        end
    endtask

    task automatic do_stall();
        pool_idle = 1'b0;
        in_data   = px[1][2];
        in_valid  = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check_eq("stall_in_ready", 32'(in_ready), 32'd0);
            check_eq("stall_win_valid", 32'(win_valid), 32'd1);
            check_eq("stall_win_idx", 32'(win_idx), 32'd0);
            check_eq("stall_win0", {12'b0, win[0]}, 32'h0_0000);
            check_eq("stall_win1", {12'b0, win[1]}, 32'h0_1000);
            check_eq("stall_win2", {12'b0, win[2]}, 32'h0_8000);
            check_eq("stall_win3", {12'b0, win[3]}, 32'h0_9000);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        pool_idle = 1'b1;
    endtask

    task automatic send_frame(input int gap_pct, input int stall_at);
        for (int r = 0; r < MH; r++) begin
            for (int c = 0; c < MW; c++) begin
                if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                    @(posedge clk);
                    #1;
                    if (rand_idle) pool_idle = ($urandom_range(2) != 0);
                end
                send_pixel(r, c);
                if (r * MW + c == stall_at) do_stall();
            end
        end
    endtask

    task automatic drain(input int frames);
        rand_idle = 1'b0;
        pool_idle = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (!win_valid) break;
        end
        @(posedge clk);
        #1;
        check_eq("queue_empty", 32'(q.size()), 32'd0);
        check_eq("frame_done_count", 32'(fd_count), 32'(frames));
        fd_count = 0;
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_win_valid", 32'(win_valid), 32'd0);
        check_eq("rst_win_idx", 32'(win_idx), 32'd0);
        check_eq("rst_frame_done", 32'(frame_done), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 4; i++) check_eq($sformatf("rst_win%0d", i), {12'b0, win[i]}, 32'd0);
        reset = 1'b0;

        // Ramp frame with a 5-cycle stall after window 0.
        for (int r = 0; r < MH; r++)
            for (int c = 0; c < MW; c++) px[r][c] = W'((r * MW + c) << 12);
        pool_idle = 1'b1;
        send_frame(0, 9);
        drain(1);

        // Extreme signed values in window 0.
        for (int r = 0; r < MH; r++)
            for (int c = 0; c < MW; c++) px[r][c] = '0;
        px[0][0] = 20'hFFFFF;
        px[0][1] = 20'h80000;
        px[1][0] = 20'h7FFFF;
        px[1][1] = 20'h00001;
        send_frame(0, -1);
        drain(1);

        // Two back-to-back random frames with input gaps and random pool_idle.
        rand_idle = 1'b1;
        for (int f = 0; f < 2; f++) begin
            for (int r = 0; r < MH; r++)
                for (int c = 0; c < MW; c++) px[r][c] = W'($urandom);
            send_frame(30, -1);
        end
        drain(2);

        // Reset mid-frame with a window pending.
        for (int r = 0; r < MH; r++)
            for (int c = 0; c < MW; c++) px[r][c] = W'(((r * MW + c) << 4) + 3);
        pool_idle = 1'b1;
        for (int p = 0; p < 15; p++) send_pixel(p / MW, p % MW);
        pool_idle = 1'b0;
        send_pixel(1, 7);
        @(negedge clk);
        check_eq("pre_rst_win_valid", 32'(win_valid), 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        q.delete();
        fd_pending = 1'b0;
        @(posedge clk);
        #1;
        check_eq("mid_rst_win_valid", 32'(win_valid), 32'd0);
        check_eq("mid_rst_win_idx", 32'(win_idx), 32'd0);
        check_eq("mid_rst_in_ready", 32'(in_ready), 32'd1);
        reset = 1'b0;

        pool_idle = 1'b1;
        for (int r = 0; r < MH; r++)
            for (int c = 0; c < MW; c++) px[r][c] = W'($urandom);
        send_frame(10, -1);
        drain(1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
